apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command interface into APB4 master transfers: one transfer at a time, two slave selects.
- Returns read data and error status on a valid/ready response channel.
- Drives the APB slave side of the subsystem, for example the DV APB memory/random-response slave models and the crypto register blocks.
- Includes an access-phase timeout so a stalled slave cannot hang the bus.

Parameters:
- TIMEOUT, 16: maximum ACCESS-phase cycles with pready low before the transfer is aborted. 0 disables the timeout.
- AW, 20: address width.
- DW, 16: data width. pstrb width is DW/8.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_sel  in  1  target slave: 0 gives psel=2'b01, 1 gives psel=2'b10
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AW  transfer address
- cmd_wdata  in  DW  write data
- cmd_strb  in  DW/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DW  read data (0 for writes)
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  abort caused by timeout
- psel  out  2  one-hot APB select
- penable  out  1  APB enable
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- pwrite  out  1  APB direction
- pstrb  out  DW/8  APB strobes
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset applies on the clk edge with reset=1. State goes to IDLE. All outputs 0 except cmd_ready=1. Timeout counter cleared.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; psel, penable, rsp_valid are 0.
  - On accept: register sel/write/addr/wdata/strb and go to SETUP.
  - pstrb is forced to 0 for reads.
- SETUP (exactly 1 cycle):
  - psel one-hot, penable=0.
  - paddr, pwrite, pwdata, pstrb driven from registers.
  - Next state is ACCESS.
- ACCESS:
  - psel held, penable=1, all APB outputs stable.
  - Each edge: if pready=1, capture prdata (reads only; writes capture 0) and pslverr, then go to RESP.
  - If pready=0, increment the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with pready still 0, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 on the same edge as counter==TIMEOUT: pready wins, and this is a normal completion.
  - pslverr is ignored when pready=0.
- RESP:
  - psel=0, penable=0, rsp_valid=1, response fields stable until accepted.
  - rsp_err = captured pslverr, or timeout.
  - On rsp_valid && rsp_ready, go to IDLE. cmd_ready rises the following cycle; there are no back-to-back transfers without an IDLE cycle.
- Latency: accept at edge N, SETUP in cycle N+1, ACCESS from cycle N+2. Zero-wait slave gives rsp_valid in cycle N+3. Each pready=0 cycle adds 1.
- cmd_* inputs are ignored outside IDLE.
- APB outputs in IDLE/RESP keep the last paddr/pwrite/pwdata; only psel/penable return to 0.
- Reset mid-transfer, in any state: next edge gives IDLE, psel=penable=0, pending response discarded.
- Counter width is ceil(log2(TIMEOUT+1)). It is cleared on entry to SETUP.

Test Plan:
- Write, zero-wait slave: cmd_sel=0, addr=20'h00010, wdata=16'hBEEF, strb=2'b11.
  - Required: psel=01 with penable=0 for one cycle, then penable=1 for one cycle with pwrite=1, pstrb=11.
  - rsp_valid in cycle N+3 with rsp_err=0, rsp_rdata=0.
- Read from slave 1 with 3 pready-low cycles, prdata=16'hABCD.
  - Required: psel=10; penable held 4 cycles with paddr stable and pstrb=00.
  - rsp_rdata=16'hABCD, rsp_err=0.
- pslverr=1 with pready=1 in ACCESS:
  - Required: rsp_err=1, rsp_timeout=0.
  - pslverr=1 during pready=0 cycles alone must not set rsp_err.
- Timeout, TIMEOUT=4, pready held 0:
  - Required: abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, psel/penable drop.
  - Repeat with pready=1 on the 4th cycle: normal completion, rsp_timeout=0.
- Response backpressure: rsp_ready=0 for 5 cycles.
  - Required: rsp_valid and fields stable, cmd_ready=0, new cmd_valid ignored.
  - After acceptance, cmd_ready=1 the next cycle.
- Reset asserted during ACCESS:
  - Required: next cycle psel=00, penable=0, rsp_valid=0, cmd_ready=1.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into single APB4 master
// transfers towards one of two slaves, and returns read data / error status on
// a valid/ready response channel. A wait counter aborts ACCESS phases that a
// stalled slave never completes.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned AW      = 20,
  parameter int unsigned DW      = 16
) (
  input  logic              clk,
  input  logic              reset,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sel,
  input  logic              cmd_write,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DW-1:0]     cmd_wdata,
  input  logic [DW/8-1:0]   cmd_strb,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB4 master side
  output logic [1:0]        psel,
  output logic              penable,
  output logic [AW-1:0]     paddr,
  output logic [DW-1:0]     pwdata,
  output logic              pwrite,
  output logic [DW/8-1:0]   pstrb,
  input  logic [DW-1:0]     prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned SW = DW / 8;
  // Wait counter wide enough to hold TIMEOUT; kept 1 bit when the timeout is off.
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // The abort fires on the edge where a further low pready would make the
  // count reach TIMEOUT, i.e. after TIMEOUT ACCESS cycles with pready low.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              tmo_hit;

  logic              cmd_ready_q;
  logic [1:0]        psel_q;
  logic              penable_q;
  logic [AW-1:0]     paddr_q;
  logic [DW-1:0]     pwdata_q;
  logic              pwrite_q;
  logic [SW-1:0]     pstrb_q;
  logic              rsp_valid_q;
  logic [DW-1:0]     rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  // Next wait count and timeout detection for the current ACCESS cycle.
  always_comb begin
    cnt_d   = cnt_q;
    tmo_hit = 1'b0;
    if (TIMEOUT != 0) begin
      cnt_d   = cnt_q + CW'(1);
      tmo_hit = (cnt_q == CNT_LAST);
    end
  end

  // Transfer FSM; every interface output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 2'b00;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // cmd_ready is high throughout IDLE, so valid alone means accept.
          if (cmd_valid) begin
            state_q     <= SETUP;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            psel_q      <= cmd_sel ? 2'b10 : 2'b01;
            penable_q   <= 1'b0;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            pwrite_q    <= cmd_write;
            // Reads never carry strobes on APB4.
            pstrb_q     <= cmd_write ? cmd_strb : '0;
          end
        end

        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end

        ACCESS: begin
          if (pready) begin
            // Completion wins even on the cycle the timeout would expire.
            state_q       <= RESP;
            psel_q        <= 2'b00;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (tmo_hit) begin
            state_q       <= RESP;
            psel_q        <= 2'b00;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        RESP: begin
          // Response fields hold until consumed; one IDLE cycle always follows.
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwrite      = pwrite_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with TIMEOUT=4. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_apb_master_bridge;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_sel;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [1:0]    cmd_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [1:0]    psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic [1:0]    pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(.TIMEOUT(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sel, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [1:0] st);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (psel !== 2'b00) begin failures++; $display("FAIL rst_psel got=%b exp=00", psel); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL rst_penable got=%b exp=0", penable); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (paddr !== 20'h0) begin failures++; $display("FAIL rst_paddr got=%h exp=00000", paddr); end
    checks++; if (pwrite !== 1'b0 || pstrb !== 2'b00 || pwdata !== 16'h0) begin failures++; $display("FAIL rst_apb_data got=%b/%b/%h exp=0/00/0000", pwrite, pstrb, pwdata); end
    checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'h0) begin failures++; $display("FAIL rst_rsp_fields got=%b/%b/%h exp=0/0/0000", rsp_err, rsp_timeout, rsp_rdata); end
  endtask

  task automatic test_write_zero_wait();
    issue(1'b0, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
    pready = 1'b1;
    pslverr = 1'b0;
    tick();  // accept edge N -> SETUP
    cmd_valid = 1'b0;
    checks++; if (psel !== 2'b01 || penable !== 1'b0) begin failures++; $display("FAIL wr_setup psel/penable got=%b/%b exp=01/0", psel, penable); end
    checks++; if (paddr !== 20'h00010 || pwdata !== 16'hBEEF || pwrite !== 1'b1 || pstrb !== 2'b11) begin failures++; $display("FAIL wr_setup_bus got=%h/%h/%b/%b exp=00010/beef/1/11", paddr, pwdata, pwrite, pstrb); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL wr_setup_cmd_ready got=%b exp=0", cmd_ready); end
    tick();  // ACCESS
    checks++; if (psel !== 2'b01 || penable !== 1'b1 || pwrite !== 1'b1 || pstrb !== 2'b11) begin failures++; $display("FAIL wr_access got=%b/%b/%b/%b exp=01/1/1/11", psel, penable, pwrite, pstrb); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_access_rsp_valid got=%b exp=0", rsp_valid); end
    tick();  // RESP in cycle N+3
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'h0) begin failures++; $display("FAIL wr_resp got=%b/%b/%b/%h exp=1/0/0/0000", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (psel !== 2'b00 || penable !== 1'b0) begin failures++; $display("FAIL wr_resp_bus got=%b/%b exp=00/0", psel, penable); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    pready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_idle got=%b/%b exp=1/0", cmd_ready, rsp_valid); end
    checks++; if (paddr !== 20'h00010 || pwrite !== 1'b1 || pwdata !== 16'hBEEF) begin failures++; $display("FAIL wr_idle_hold got=%h/%b/%h exp=00010/1/beef", paddr, pwrite, pwdata); end
  endtask

  task automatic test_read_wait();
    issue(1'b1, 1'b0, 20'h12345, 16'h5555, 2'b11);
    pready = 1'b0;
    pslverr = 1'b1;
    prdata = 16'h1111;
    tick();  // SETUP
    cmd_valid = 1'b0;
    checks++; if (psel !== 2'b10 || penable !== 1'b0 || pwrite !== 1'b0 || pstrb !== 2'b00) begin failures++; $display("FAIL rd_setup got=%b/%b/%b/%b exp=10/0/0/00", psel, penable, pwrite, pstrb); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (psel !== 2'b10 || penable !== 1'b1 || paddr !== 20'h12345 || pstrb !== 2'b00 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_access%0d got=%b/%b/%h/%b/%b exp=10/1/12345/00/0", i, psel, penable, paddr, pstrb, rsp_valid); end
      if (i == 3) begin
        pready = 1'b1;
        pslverr = 1'b0;
        prdata = 16'hABCD;
      end
    end
    tick();
    pready = 1'b0;
    prdata = 16'h0000;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hABCD || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin failures++; $display("FAIL rd_resp got=%b/%h/%b/%b exp=1/abcd/0/0", rsp_valid, rsp_rdata, rsp_err, rsp_timeout); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rd_idle_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_slverr();
    issue(1'b0, 1'b1, 20'h00200, 16'h1234, 2'b01);
    pready = 1'b1;
    pslverr = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pready = 1'b0;
    pslverr = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'h0) begin failures++; $display("FAIL slverr_resp got=%b/%b/%b/%h exp=1/1/0/0000", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    // Stalled slave: four low-pready ACCESS cycles then abort.
    issue(1'b0, 1'b0, 20'h0ABCD, 16'h0000, 2'b00);
    pready = 1'b0;
    prdata = 16'hFFFF;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (penable !== 1'b1 || psel !== 2'b01 || rsp_valid !== 1'b0) begin failures++; $display("FAIL tmo_access%0d got=%b/%b/%b exp=1/01/0", i, penable, psel, rsp_valid); end
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 16'h0) begin failures++; $display("FAIL tmo_resp got=%b/%b/%b/%h exp=1/1/1/0000", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (psel !== 2'b00 || penable !== 1'b0) begin failures++; $display("FAIL tmo_bus got=%b/%b exp=00/0", psel, penable); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // pready arrives in the 4th ACCESS cycle: normal completion.
    issue(1'b0, 1'b0, 20'h0ABCE, 16'h0000, 2'b00);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL tmo_edge_access%0d got=%b/%b exp=1/0", i, penable, rsp_valid); end
      if (i == 3) begin
        pready = 1'b1;
        prdata = 16'h0F0F;
      end
    end
    tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'h0F0F) begin failures++; $display("FAIL tmo_edge_resp got=%b/%b/%b/%h exp=1/0/0/0f0f", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    issue(1'b1, 1'b1, 20'hFFFFF, 16'h8001, 2'b10);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pready = 1'b0;
    // A new command during RESP must be ignored.
    issue(1'b0, 1'b0, 20'h00055, 16'h7777, 2'b01);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'h0 || cmd_ready !== 1'b0 || psel !== 2'b00 || paddr !== 20'hFFFFF) begin failures++; $display("FAIL bp_hold%0d got=%b/%b/%b/%h/%b/%b/%h exp=1/0/0/0000/0/00/fffff", i, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, psel, paddr); end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 2'b00 || paddr !== 20'hFFFFF) begin failures++; $display("FAIL bp_release got=%b/%b/%b/%h exp=1/0/00/fffff", cmd_ready, rsp_valid, psel, paddr); end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 20'h00777, 16'h0000, 2'b00);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL rmid_in_access got=%b exp=1", penable); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (psel !== 2'b00 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_after got=%b/%b/%b/%b exp=00/0/0/1", psel, penable, rsp_valid, cmd_ready); end
    issue(1'b0, 1'b0, 20'h00321, 16'h0000, 2'b00);
    pready = 1'b1;
    prdata = 16'h4242;
    tick();
    cmd_valid = 1'b0;
    checks++; if (psel !== 2'b01 || penable !== 1'b0 || paddr !== 20'h00321) begin failures++; $display("FAIL rmid_setup got=%b/%b/%h exp=01/0/00321", psel, penable, paddr); end
    tick();
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL rmid_access got=%b exp=1", penable); end
    tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h4242 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin failures++; $display("FAIL rmid_resp got=%b/%h/%b/%b exp=1/4242/0/0", rsp_valid, rsp_rdata, rsp_err, rsp_timeout); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b/%b exp=1/0", cmd_ready, rsp_valid); end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_sel   = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
